// File: rtl/write_back_if.sv
// MEM-to-WB stage bundle: MEM-stage results in, register-file write port out.
// The retire_count signal exists only when WB_RETIRE_CNT_EN is defined.
interface write_back_if #(
  parameter int unsigned CNT_W = 32
);
  logic        mem_valid;
  logic [31:0] mem_instr;
  logic [31:0] mem_alu_result;
  logic [31:0] mem_read_data;
  logic [31:0] mem_pc;
  logic [4:0]  mem_dest_addr;
  logic        mem_reg_write;
  logic        mem_to_reg;
  logic        mem_link;
  logic [1:0]  mem_load_size;
  logic        mem_load_unsigned;
  logic        stall;
  logic [31:0] write_result;
  logic [4:0]  write_addr;
  logic        register_write;
  logic        done;
`ifdef WB_RETIRE_CNT_EN
  logic [CNT_W-1:0] retire_count;
`endif

  modport master (
    output mem_valid, mem_instr, mem_alu_result, mem_read_data, mem_pc,
    output mem_dest_addr, mem_reg_write, mem_to_reg, mem_link,
    output mem_load_size, mem_load_unsigned, stall,
    input  write_result, write_addr, register_write, done
`ifdef WB_RETIRE_CNT_EN
    , input retire_count
`endif
  );

  modport slave (
    input  mem_valid, mem_instr, mem_alu_result, mem_read_data, mem_pc,
    input  mem_dest_addr, mem_reg_write, mem_to_reg, mem_link,
    input  mem_load_size, mem_load_unsigned, stall,
    output write_result, write_addr, register_write, done
`ifdef WB_RETIRE_CNT_EN
    , output retire_count
`endif
  );
endinterface

// File: rtl/write_back.sv
// WB stage of the 5-stage MIPS pipeline: registered result select, sub-word load
// extraction, r0 write suppression and halt detection. Optional retire counter: WB_RETIRE_CNT_EN.
module write_back #(
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF,
  parameter int unsigned CNT_W     = 32
) (
  input logic         clk,
  input logic         reset,
  write_back_if.slave bus
);
  typedef enum logic [0:0] {ST_RUN = 1'b0, ST_HALTED = 1'b1} state_e;

  state_e      state_q;
  logic [31:0] result_q;
  logic [4:0]  addr_q;
  logic        we_q;
  logic        done_q;
  logic [31:0] load_d;
  logic [31:0] result_d;
  logic [7:0]  byte_s;
  logic [15:0] half_s;
  logic        retire_s;
  logic        halt_s;

  if (CNT_W < 1) begin : g_cnt_w_check
    $error("CNT_W must be at least 1");
  end

  assign retire_s = (state_q == ST_RUN) && !bus.stall && bus.mem_valid;
  assign halt_s   = (bus.mem_instr == HALT_WORD);

  // Little-endian lane extraction; half loads ignore address bit 0.
  always_comb begin
    byte_s = 8'h00;
    half_s = 16'h0000;
    load_d = bus.mem_read_data;
    case (bus.mem_alu_result[1:0])
      2'd0:    byte_s = bus.mem_read_data[7:0];
      2'd1:    byte_s = bus.mem_read_data[15:8];
      2'd2:    byte_s = bus.mem_read_data[23:16];
      2'd3:    byte_s = bus.mem_read_data[31:24];
      default: byte_s = 8'h00;
    endcase
    if (bus.mem_alu_result[1]) begin
      half_s = bus.mem_read_data[31:16];
    end else begin
      half_s = bus.mem_read_data[15:0];
    end
    case (bus.mem_load_size)
      2'b01:   load_d = bus.mem_load_unsigned ? {16'h0000, half_s} : {{16{half_s[15]}}, half_s};
      2'b10:   load_d = bus.mem_load_unsigned ? {24'h000000, byte_s} : {{24{byte_s[7]}}, byte_s};
      default: load_d = bus.mem_read_data;
    endcase
  end

  always_comb begin
    result_d = bus.mem_alu_result;
    if (bus.mem_link) begin
      result_d = bus.mem_pc + 32'd8;
    end else if (bus.mem_to_reg) begin
      result_d = load_d;
    end else begin
      result_d = bus.mem_alu_result;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_RUN;
      result_q <= 32'h0000_0000;
      addr_q   <= 5'd0;
      we_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          we_q <= 1'b0;
          if (retire_s) begin
            if (halt_s) begin
              state_q <= ST_HALTED;
              done_q  <= 1'b1;
            end else begin
              result_q <= result_d;
              addr_q   <= bus.mem_dest_addr;
              we_q     <= bus.mem_reg_write && (bus.mem_dest_addr != 5'd0);
            end
          end
        end
        ST_HALTED: begin
          we_q   <= 1'b0;
          done_q <= 1'b1;
        end
        default: begin
          state_q <= ST_RUN;
          we_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.write_result   = result_q;
  assign bus.write_addr     = addr_q;
  assign bus.register_write = we_q;
  assign bus.done           = done_q;

`ifdef WB_RETIRE_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Counts every retiring instruction including the halt word; frozen once halted.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (retire_s) begin
      cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_q <= cnt_q;
    end
  end

  assign bus.retire_count = cnt_q;
`endif
endmodule

// File: tb/tb_write_back.sv
// Scoreboard bench for write_back: expected writes are queued at issue time and
// popped by a monitor whenever register_write is seen; hold/halt behaviour checked inline.
module tb_write_back;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  write_back_if #(.CNT_W(32)) bus ();
  write_back #(.HALT_WORD(32'hFFFF_FFFF), .CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  addr;
  } wr_t;

  wr_t exp_q[$];
  wr_t exp_e;
  int  checks   = 0;
  int  failures = 0;

  localparam logic [31:0] RD  = 32'h80FF_7F01;
  localparam logic [31:0] NOP = 32'h0000_0000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every write the DUT presents must match the oldest queued expectation.
  always @(posedge clk) begin
    #2;
    if (bus.register_write === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got addr %0d data %h, expected no write",
                 bus.write_addr, bus.write_result);
      end else begin
        exp_e = exp_q.pop_front();
        check("wr_data", bus.write_result, exp_e.data);
        check("wr_addr", {27'd0, bus.write_addr}, {27'd0, exp_e.addr});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic valid, input logic stl, input logic [31:0] instr,
                        input logic [31:0] alu, input logic [31:0] pc, input logic [4:0] dest,
                        input logic rw, input logic toreg, input logic link,
                        input logic [1:0] size, input logic uns);
    bus.mem_valid         = valid;
    bus.stall             = stl;
    bus.mem_instr         = instr;
    bus.mem_alu_result    = alu;
    bus.mem_read_data     = RD;
    bus.mem_pc            = pc;
    bus.mem_dest_addr     = dest;
    bus.mem_reg_write     = rw;
    bus.mem_to_reg        = toreg;
    bus.mem_link          = link;
    bus.mem_load_size     = size;
    bus.mem_load_unsigned = uns;
  endtask

  // Issue one valid non-stalled instruction; queue the write it should produce.
  task automatic op(input logic [31:0] alu, input logic [31:0] pc, input logic [4:0] dest,
                    input logic rw, input logic toreg, input logic link,
                    input logic [1:0] size, input logic uns,
                    input logic wr_exp, input logic [31:0] data_exp);
    set_in(1'b1, 1'b0, NOP, alu, pc, dest, rw, toreg, link, size, uns);
    if (wr_exp) exp_q.push_back('{data: data_exp, addr: dest});
    tick();
  endtask

  task automatic bubble();
    set_in(1'b0, 1'b0, NOP, 32'h0, 32'h0, 5'd1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
    tick();
  endtask

  task automatic check_cnt(input string name, input logic [31:0] exp);
`ifdef WB_RETIRE_CNT_EN
    check(name, bus.retire_count, exp);
`endif
  endtask

  initial begin
    reset = 1'b1;
    set_in(1'b0, 1'b0, NOP, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    tick();
    tick();
    check("rst_result", bus.write_result, 32'h0);
    check("rst_addr", {27'd0, bus.write_addr}, 32'd0);
    check("rst_we", {31'd0, bus.register_write}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check_cnt("rst_cnt", 32'd0);
    reset = 1'b0;

    // ALU write, then a bubble: single-cycle enable, data held.
    op(32'h1234_5678, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 32'h1234_5678);
    check("alu_we", {31'd0, bus.register_write}, 32'd1);
    bubble();
    check("bubble_we", {31'd0, bus.register_write}, 32'd0);
    check("bubble_result", bus.write_result, 32'h1234_5678);
    check("bubble_addr", {27'd0, bus.write_addr}, 32'd5);

    // Byte / half / word loads from 80FF_7F01.
    op(32'h0000_0003, 32'h0, 5'd6,  1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 32'hFFFF_FF80);
    op(32'h0000_0003, 32'h0, 5'd7,  1'b1, 1'b1, 1'b0, 2'b10, 1'b1, 1'b1, 32'h0000_0080);
    op(32'h0000_0001, 32'h0, 5'd8,  1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 32'h0000_007F);
    op(32'h0000_0000, 32'h0, 5'd9,  1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1, 32'h0000_7F01);
    op(32'h0000_0002, 32'h0, 5'd10, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1, 32'hFFFF_80FF);
    op(32'h0000_0003, 32'h0, 5'd11, 1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 1'b1, 32'h0000_80FF);
    op(32'h0000_0002, 32'h0, 5'd12, 1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 1'b1, 32'h80FF_7F01);

    // r0 suppression, link priority with wrap, and reg_write=0.
    op(32'hDEAD_BEEF, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0);
    check("r0_we", {31'd0, bus.register_write}, 32'd0);
    check("r0_addr", {27'd0, bus.write_addr}, 32'd0);
    check("r0_result", bus.write_result, 32'hDEAD_BEEF);
    op(32'h0000_1111, 32'hFFFF_FFFC, 5'd31, 1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 1'b1, 32'h0000_0004);
    op(32'h0000_5555, 32'h0, 5'd3, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0);
    check("norw_we", {31'd0, bus.register_write}, 32'd0);

    // Three-cycle stall mid-stream; the stalled instruction retires on release.
    op(32'hA5A5_A5A5, 32'h0, 5'd13, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 32'hA5A5_A5A5);
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 1'b1, NOP, 32'h0BAD_0BAD, 32'h0, 5'd14, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
      tick();
      check("stall_we", {31'd0, bus.register_write}, 32'd0);
      check("stall_result", bus.write_result, 32'hA5A5_A5A5);
      check("stall_addr", {27'd0, bus.write_addr}, 32'd13);
    end
    op(32'h0BAD_0BAD, 32'h0, 5'd14, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 32'h0BAD_0BAD);
    bubble();

    // Fresh reset, then 4 instructions + halt.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_cnt("cnt_after_rst", 32'd0);
    op(32'h0000_0011, 32'h0, 5'd1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 32'h0000_0011);
    op(32'h0000_0022, 32'h0, 5'd2, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 32'h0000_0022);
    bubble();
    op(32'h0000_0033, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0);
    op(32'h0000_0044, 32'h0, 5'd4, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 32'h0000_0044);
    check("pre_halt_done", {31'd0, bus.done}, 32'd0);
    set_in(1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0000_0077, 32'h0, 5'd20, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
    tick();
    check("halt_done", {31'd0, bus.done}, 32'd1);
    check("halt_we", {31'd0, bus.register_write}, 32'd0);
    check("halt_result", bus.write_result, 32'h0000_0044);
    check_cnt("halt_cnt", 32'd5);
    for (int i = 0; i < 2; i++) begin
      op(32'h0000_0099, 32'h0, 5'd21, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0);
      check("halted_we", {31'd0, bus.register_write}, 32'd0);
      check("halted_done", {31'd0, bus.done}, 32'd1);
      check("halted_result", bus.write_result, 32'h0000_0044);
      check_cnt("halted_cnt", 32'd5);
    end

    // Reset while halted returns to RUN.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst2_done", {31'd0, bus.done}, 32'd0);
    check("rst2_result", bus.write_result, 32'h0);
    op(32'hCAFE_F00D, 32'h0, 5'd22, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 32'hCAFE_F00D);
    check("resume_we", {31'd0, bus.register_write}, 32'd1);
    check("resume_done", {31'd0, bus.done}, 32'd0);
    check_cnt("resume_cnt", 32'd1);
    bubble();
    bubble();
    check("queue_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
